// File: rtl/uart_tx_frame.sv
// uart_tx_frame: serial frame transmitter with a valid/ready byte input.
// Emits start, LSB-first data, optional parity and one or two stop bits.
// Bit timing comes from an external baud counter. This block enables that
// counter and restarts it at the beginning of every frame.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic                  baud_tick,
    output logic                  baud_en,
    output logic                  baud_clr,
    output logic                  txd,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    localparam logic [CW-1:0] LAST_DATA = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt;
    logic                  par_bit;
    logic                  accept;
    logic                  advance;

    // Handshake and bit-advance qualifiers, all decoded from registered state
    always_comb begin
        tx_ready = (state == IDLE) && !reset;
        accept   = tx_valid && tx_ready;
        advance  = baud_tick && !baud_clr && (state != IDLE);
        baud_en  = (state != IDLE);
        busy     = (state != IDLE);
    end

    // Frame sequencer: the shift register holds the current data bit in its LSB
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            par_bit   <= 1'b0;
            txd       <= 1'b1;
            baud_clr  <= 1'b0;
        end else begin
            baud_clr <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= tx_data;
                        bit_cnt   <= '0;
                        par_bit   <= (^tx_data) ^ (PARITY == 2);
                        state     <= START;
                        txd       <= 1'b0;
                        baud_clr  <= 1'b1;
                    end
                end
                START: begin
                    if (advance) begin
                        state <= DATA;
                        txd   <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (advance) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= PAR;
                                txd   <= par_bit;
                            end else begin
                                state <= STOP;
                                txd   <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            txd       <= shift_reg[1];
                        end
                    end
                end
                PAR: begin
                    if (advance) begin
                        state <= STOP;
                        txd   <= 1'b1;
                    end
                end
                STOP: begin
                    if (advance) begin
                        if (bit_cnt == LAST_STOP) begin
                            state   <= IDLE;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: four parameter variants of uart_tx_frame, each fed by a
// behavioural baud counter, with a queue of expected frames drained by a monitor.
module tb_uart_tx_frame;

    localparam int NV = 4;
    localparam int DWS  [NV] = '{8, 8, 8, 9};
    localparam int PARS [NV] = '{0, 1, 2, 1};
    localparam int SBS  [NV] = '{1, 1, 2, 2};
    localparam int PERS [NV] = '{4, 3, 5, 2};

    logic clk = 1'b0;
    int   checks = 0;
    int   failures = 0;

    // Free-running bench clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int inst,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 60)
                $display("[TB] FAIL %s (variant %0d): got %0h, expected %0h", name, inst, act, exp);
        end
    endtask

    for (genvar g = 0; g < NV; g++) begin : gv
        localparam int DW  = DWS[g];
        localparam int PAR = PARS[g];
        localparam int SB  = SBS[g];
        localparam int P   = PERS[g];

        logic          rst = 1'b1;
        logic [DW-1:0] tx_data = '0;
        logic          tx_valid = 1'b0;
        logic          tx_ready, baud_tick, baud_en, baud_clr, txd, busy;
        logic          spur = 1'b0;
        logic          ctick;
        int            bcnt = 0;

        logic [15:0] exp_bits[$];
        int          exp_len[$];
        int          tmo_err = 0;
        bit          final_check = 1'b0;
        bit          done = 1'b0;

        bit          active = 1'b0, rst_prev = 1'b0, accept_seen = 1'b0;
        bit          frame_ended = 1'b0, first_cyc = 1'b0;
        logic [15:0] cur_bits = '1;
        int          cur_len = 0, idx = 0, cyc = 0;

        uart_tx_frame #(
            .DATA_WIDTH(DW),
            .PARITY    (PAR),
            .STOP_BITS (SB)
        ) dut (
            .clk      (clk),
            .reset    (rst),
            .tx_data  (tx_data),
            .tx_valid (tx_valid),
            .tx_ready (tx_ready),
            .baud_tick(baud_tick),
            .baud_en  (baud_en),
            .baud_clr (baud_clr),
            .txd      (txd),
            .busy     (busy)
        );

        // Baud counter model: ticks every P cycles after a clear, idle when disabled
        always @(posedge clk) begin
            if (rst || baud_clr || !baud_en || ctick) bcnt <= 0;
            else                                      bcnt <= bcnt + 1;
        end

        assign ctick     = baud_en && (bcnt == P - 1);
        assign baud_tick = ctick | spur;

        // Expected line sequence for one frame, straight from the frame format
        function automatic void buildFrame(input logic [DW-1:0] d,
                                           output logic [15:0] bits, output int len);
            int ones;
            ones = $countones(d);
            bits = '1;
            len  = 0;
            bits[len] = 1'b0; len++;
            for (int i = 0; i < DW; i++) begin bits[len] = d[i]; len++; end
            if (PAR == 1)      begin bits[len] = 1'(ones % 2);       len++; end
            else if (PAR == 2) begin bits[len] = 1'((ones + 1) % 2); len++; end
            for (int i = 0; i < SB; i++) begin bits[len] = 1'b1; len++; end
        endfunction

        task automatic applyStimulus(input logic [DW-1:0] d, input int gap, input bit keep);
            int          n;
            logic [15:0] b;
            int          l;
            if (gap > 0) begin
                tx_valid = 1'b0;
                for (int i = 0; i < gap; i++) begin
                    spur = busy ? 1'b0 : 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
            spur     = busy ? 1'b0 : 1'($urandom_range(0, 1));
            tx_valid = 1'b1;
            tx_data  = d;
            n = 0;
            while (n <= 600) begin
                @(negedge clk);
                if (tx_ready) break;
                n++;
            end
            if (n > 600) begin
                tmo_err++;
                tx_valid = 1'b0;
                spur     = 1'b0;
            end else begin
                buildFrame(d, b, l);
                exp_bits.push_back(b);
                exp_len.push_back(l);
                @(posedge clk); #1;
                spur     = 1'($urandom_range(0, 1));
                tx_data  = DW'($urandom);
                tx_valid = keep;
                @(posedge clk); #1;
                spur = 1'b0;
            end
        endtask

        // Stimulus: directed frames from the test plan, a mid-frame reset, then random traffic
        initial begin
            int adv, n;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            applyStimulus(DW'(8'hA5), 2, 1'b0);
            applyStimulus(DW'(8'h07), 2, 1'b0);
            applyStimulus(DW'(8'h00), 1, 1'b1);
            applyStimulus(DW'(8'hFF), 0, 1'b0);
            applyStimulus(DW'(8'h5A), 3, 1'b0);
            adv = 0;
            n   = 0;
            while (adv < 4 && n < 600) begin
                @(negedge clk);
                if (baud_tick && !baud_clr && busy) adv++;
                n++;
            end
            if (adv < 4) tmo_err++;
            @(posedge clk); #1;
            rst      = 1'b1;
            tx_valid = 1'b1;
            tx_data  = DW'($urandom);
            repeat (2) begin @(posedge clk); #1; end
            rst      = 1'b0;
            tx_valid = 1'b0;
            applyStimulus(DW'(8'h3C), 2, 1'b0);
            for (int i = 0; i < 8; i++)
                applyStimulus(DW'($urandom), $urandom_range(0, 3),
                              (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0);
            tx_valid = 1'b0;
            n = 0;
            while (busy && n < 600) begin @(posedge clk); n++; end
            repeat (3) @(posedge clk);
            final_check = 1'b1;
        end

        // Monitor: pops one expected frame per frame start and checks every cycle of it
        always @(negedge clk) begin
            if (rst) begin
                checkOutput("ready_in_reset", g, 32'(tx_ready), 32'd0);
                if (rst_prev)
                    checkOutput("reset_outputs{txd,busy,en,clr}", g,
                                {28'd0, txd, busy, baud_en, baud_clr}, 32'b1000);
                active      = 1'b0;
                frame_ended = 1'b0;
                accept_seen = 1'b0;
            end else begin
                if (accept_seen)
                    checkOutput("accept_latency{txd,busy,ready,clr}", g,
                                {28'd0, txd, busy, tx_ready, baud_clr}, 32'b0101);
                if (frame_ended)
                    checkOutput("ready_after_stop{busy,ready}", g,
                                {30'd0, busy, tx_ready}, 32'b01);
                frame_ended = 1'b0;
                checkOutput("ready_vs_busy", g, 32'(tx_ready), 32'(!busy));
                checkOutput("en_vs_busy", g, 32'(baud_en), 32'(busy));
                if (!busy)
                    checkOutput("idle_line{txd,clr}", g, {30'd0, txd, baud_clr}, 32'b10);
                if (active && !busy) begin
                    checkOutput("frame_cut_short_bits", g, 32'(idx), 32'(cur_len));
                    active = 1'b0;
                end
                if (busy && !active) begin
                    if (exp_len.size() == 0) begin
                        checkOutput("unexpected_frame", g, 32'd1, 32'd0);
                    end else begin
                        cur_bits  = exp_bits.pop_front();
                        cur_len   = exp_len.pop_front();
                        active    = 1'b1;
                        idx       = 0;
                        cyc       = 0;
                        first_cyc = 1'b1;
                    end
                end
                if (active) begin
                    cyc++;
                    checkOutput("clr_first_cycle_only", g, 32'(baud_clr), 32'(first_cyc));
                    first_cyc = 1'b0;
                    checkOutput($sformatf("txd_bit%0d", idx), g, 32'(txd), 32'(cur_bits[idx]));
                    if (baud_tick && !baud_clr) begin
                        checkOutput($sformatf("bit%0d_cycles", idx), g, 32'(cyc),
                                    32'((idx == 0) ? P + 1 : P));
                        idx++;
                        cyc = 0;
                        if (idx == cur_len) begin
                            active      = 1'b0;
                            frame_ended = 1'b1;
                        end
                    end
                end
                accept_seen = tx_valid && tx_ready;
            end
            if (final_check && !done) begin
                checkOutput("frames_left_in_queue", g, 32'(exp_len.size()), 32'd0);
                checkOutput("handshake_timeouts", g, 32'(tmo_err), 32'd0);
                checkOutput("frame_open_at_end", g, 32'(active), 32'd0);
                done = 1'b1;
            end
            rst_prev = rst;
        end
    end

    // Wait for every variant to finish, then report
    initial begin
        bit all_done;
        all_done = 1'b0;
        for (int c = 0; c < 60000 && !all_done; c++) begin
            @(posedge clk);
            all_done = gv[0].done && gv[1].done && gv[2].done && gv[3].done;
        end
        if (!all_done) begin
            $display("[TB] FAIL watchdog: got unfinished variants, expected all done");
            $fatal(1, "[TB] watchdog expired");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial frame transmitter with a valid/ready byte input. It sits directly downstream of the baud-rate `counter` primitive and consumes that counter's one-cycle bit-period tick. It also drives the counter's enable and restart so that bit timing is aligned to the start of each frame. The serialized line `txd` goes to the SoC UART pin.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame. Legal range is 5..9.
- `PARITY`, default 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: number of stop bits. Legal values are 1 or 2.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `tx_data`  in  `DATA_WIDTH`  payload. Sampled only on an accept edge.
- `tx_valid`  in  1  upstream has a payload.
- `tx_ready`  out  1  block can accept a payload.
- `baud_tick`  in  1  one-cycle bit-period pulse from the baud counter (its `top`, qualified externally).
- `baud_en`  out  1  enable for the baud counter.
- `baud_clr`  out  1  restart for the baud counter (ORed into its reset externally).
- `txd`  out  1  serial line. Idles high.
- `busy`  out  1  a frame is in progress.

## Operation
- FSM states are IDLE, START, DATA, PAR and STOP.
- An accept occurs on a rising edge where `tx_valid && tx_ready`.
- `tx_ready` = (state == IDLE) and `reset` is low. It is derived combinationally from the registered state.
- On accept:
  - latch `tx_data` into the shift register;
  - clear the bit counter;
  - go to START.
- Bit advance: a rising edge where `baud_tick == 1 && baud_clr == 0` and state != IDLE. `baud_tick` is ignored in IDLE and during the `baud_clr` cycle.
- Transitions, each taken on a bit advance unless noted:
  - START -> DATA.
  - DATA: shift right, LSB first. After `DATA_WIDTH` advances, go to PAR if `PARITY != 0`, otherwise to STOP.
  - PAR -> STOP.
  - STOP: after `STOP_BITS` advances, go to IDLE.
- `txd` per state (all registered):
  - IDLE: 1.
  - START: 0.
  - DATA: current LSB of the shift register.
  - PAR: XOR of the latched payload for even parity; its inverse for odd parity.
  - STOP: 1.
- `baud_en` = 1 in every state except IDLE.
- `baud_clr` = 1 for exactly the first cycle of START, then 0 for the rest of the frame.
- `busy` = 1 in every state except IDLE.
- `tx_data` changes after an accept have no effect on the frame in flight. `tx_valid` held high while busy has no effect until `tx_ready` returns.
- The bit counter width is `$clog2(DATA_WIDTH+1)`. It never wraps within a frame.

## Timing
- Reset values, present from the first edge with `reset` high:
  - `txd` = 1, `tx_ready` = 0 while `reset` is high and 1 after it, `busy` = 0;
  - `baud_en` = 0, `baud_clr` = 0;
  - state = IDLE; shift register and bit counter = 0.
- Reset mid-frame: the frame is aborted with no stop bit. `txd` = 1 and state = IDLE on the next edge. An accept is not possible while `reset` is high.
- Latency: if accept happens at edge E, then `txd` = 0, `busy` = 1, `tx_ready` = 0 and `baud_clr` = 1 from E+1.
- Bit durations:
  - START ends on the first qualifying tick after the clear cycle.
  - With the counter ticking every P cycles after a clear, the START bit is P+1 cycles and each later bit is P cycles.
  - Every later bit ends on its own qualifying tick.
- Frame length in ticks: 1 + `DATA_WIDTH` + (`PARITY` != 0) + `STOP_BITS`.
- After the final stop tick, state is IDLE and `tx_ready` = 1 from the next cycle. Back-to-back frames therefore have exactly one IDLE cycle between them, with `txd` staying high.
- `baud_tick` in the same cycle as an accept is ignored.
- `baud_tick` held high for several cycles advances one bit per cycle. A single-cycle tick is the upstream contract.

## Test plan
- Default parameters, tick every 4 cycles, send 0xA5 → `txd` bit sequence 0,1,0,1,0,0,1,0,1,1; 10 ticks total; `tx_ready` high again one cycle after the tenth tick.
- `PARITY`=1 with 0xA5 → parity bit 0. `PARITY`=2 with 0xA5 → parity bit 1. `PARITY`=1 with 0x07 → parity bit 1. Each frame is 11 ticks.
- `STOP_BITS`=2 with 0x00 → 0, then eight 0s, then 1,1. `busy` falls only after the 11th tick.
- `tx_valid` held high with 0x00 followed by 0xFF → exactly two accepts; one IDLE cycle between frames; second frame reads 0,1×8,1. `tx_data` changed mid-frame does not alter the frame in flight.
- `reset` asserted during the DATA bit 3 of 0x5A → next edge gives `txd`=1, `busy`=0, `baud_en`=0. After reset, 0x3C transmits cleanly.
- `baud_tick` pulsed during IDLE and during the `baud_clr` cycle → no state change; START still lasts until the next tick.
